// File: rtl/peripheral_bus.sv
// Memory-mapped peripheral block at 0x4000_0000: reloadable timer with irq,
// LED register, free-running system tick and a multiplexed 4-digit display.
module peripheral_bus #(
  parameter logic [15:0] SCAN_DIV = 16'd50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] ReadData,
  output logic [7:0]  leds,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        irq
);

  localparam logic [2:0] OFF_TH      = 3'd0;
  localparam logic [2:0] OFF_TL      = 3'd1;
  localparam logic [2:0] OFF_TCON    = 3'd2;
  localparam logic [2:0] OFF_LED     = 3'd3;
  localparam logic [2:0] OFF_DIGITS  = 3'd4;
  localparam logic [2:0] OFF_SYSTICK = 3'd5;

  logic [31:0] th;
  logic [31:0] tl;
  logic [2:0]  tcon;
  logic [7:0]  led;
  logic [15:0] digits;
  logic [31:0] systick;
  logic [15:0] prescale;
  logic [1:0]  digit_idx;

  logic [2:0]  offset;
  logic        hit;
  logic        wr_th, wr_tl, wr_tcon, wr_led, wr_digits, wr_systick;
  logic        tl_max;
  logic        reload;
  logic        set_status;
  logic        scan_tc;
  logic [3:0]  nibble;
  logic [31:0] rdata;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^Address[1:0];

  // Address decode: six word registers, offsets 6 and 7 are holes
  assign offset = Address[4:2];
  assign hit    = (Address[31:5] == 27'h2000000) && (offset <= OFF_SYSTICK);

  assign wr_th      = MemWrite & hit & (offset == OFF_TH);
  assign wr_tl      = MemWrite & hit & (offset == OFF_TL);
  assign wr_tcon    = MemWrite & hit & (offset == OFF_TCON);
  assign wr_led     = MemWrite & hit & (offset == OFF_LED);
  assign wr_digits  = MemWrite & hit & (offset == OFF_DIGITS);
  assign wr_systick = MemWrite & hit & (offset == OFF_SYSTICK);

  // A software write to TL takes priority over both increment and reload
  assign tl_max     = (tl == 32'hFFFF_FFFF);
  assign reload     = tcon[0] & tl_max & ~wr_tl;
  assign set_status = reload & tcon[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th <= '0;
    end else if (wr_th) begin
      th <= WriteData;
    end
  end

  // Reload samples the pre-edge TH, so a same-cycle TH write waits one reload
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tl <= '0;
    end else if (wr_tl) begin
      tl <= WriteData;
    end else if (tcon[0]) begin
      tl <= tl_max ? th : tl + 32'd1;
    end
  end

  // Status set from a reload beats a concurrent software clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcon <= '0;
    end else if (wr_tcon) begin
      tcon <= {WriteData[2] | set_status, WriteData[1:0]};
    end else if (set_status) begin
      tcon[2] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led <= '0;
    end else if (wr_led) begin
      led <= WriteData[7:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digits <= '0;
    end else if (wr_digits) begin
      digits <= WriteData[15:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      systick <= '0;
    end else if (wr_systick) begin
      systick <= WriteData;
    end else begin
      systick <= systick + 32'd1;
    end
  end

  assign scan_tc = (prescale == SCAN_DIV - 16'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescale  <= '0;
      digit_idx <= '0;
    end else if (scan_tc) begin
      prescale  <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      prescale  <= prescale + 16'd1;
    end
  end

  always_comb begin
    rdata = '0;
    case (offset)
      OFF_TH:      rdata = th;
      OFF_TL:      rdata = tl;
      OFF_TCON:    rdata = {29'd0, tcon};
      OFF_LED:     rdata = {24'd0, led};
      OFF_DIGITS:  rdata = {16'd0, digits};
      OFF_SYSTICK: rdata = systick;
      default:     rdata = '0;
    endcase
  end

  assign ReadData = (MemRead & hit) ? rdata : 32'd0;

  always_comb begin
    nibble = digits[3:0];
    case (digit_idx)
      2'd0: nibble = digits[3:0];
      2'd1: nibble = digits[7:4];
      2'd2: nibble = digits[11:8];
      2'd3: nibble = digits[15:12];
      default: nibble = digits[3:0];
    endcase
  end

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  always_comb begin
    seg = 7'b1111111;
    case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end

  assign an   = ~(4'b0001 << digit_idx);
  assign leds = led;
  assign irq  = tcon[1] & tcon[2];

endmodule

// File: doc/peripheral_bus.md
# peripheral_bus

Memory-mapped peripheral block on the single-cycle CPU's data-memory port, downstream of the ALU/data-memory stage. It decodes the ALU-computed address in the 0x4000_0000 window, provides a reloadable timer with interrupt, an LED register, a free-running system tick counter and a multiplexed 4-digit seven-segment driver. The CPU top-level muxes `ReadData` from this block whenever `Address[31:28] == 4'h4`.

## Interface
- `SCAN_DIV`, 16'd50000: clock cycles per seven-segment digit slot; legal range 1..65535.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `Address`  in  32  byte address from the ALU result; `Address[1:0]` ignored.
- `WriteData`  in  32  store data (rt register value).
- `MemRead`  in  1  load strobe.
- `MemWrite`  in  1  store strobe; qualified by address decode.
- `ReadData`  out  32  load data, combinational.
- `leds`  out  8  LED register.
- `an`  out  4  seven-segment anodes, active-low, one-hot-low.
- `seg`  out  7  segments {g..a}, active-low.
- `irq`  out  1  timer interrupt request, level.

## Operation
- Decode: hit when `Address[31:5] == 27'h2000000` and word offset `Address[4:2]` is 0..5. Offset 6, 7 or no hit: writes ignored, reads return 0.
- Register map: 0x00 TH (32b, reload value); 0x04 TL (32b, counter); 0x08 TCON (bits [2:0], upper bits read 0); 0x0C LED (bits [7:0]); 0x10 DIGITS (bits [15:0], four hex nibbles, [3:0] = rightmost digit); 0x14 SYSTICK (32b).
- TCON: bit0 = enable, bit1 = irq enable, bit2 = irq status.
- `irq = TCON[1] & TCON[2]`.
- Timer: when TCON[0] = 1, TL increments by 1 each cycle. If TL == 32'hFFFF_FFFF, the next value is TH instead of wrap to 0. That reload cycle sets TCON[2] if TCON[1] = 1.
- SYSTICK increments by 1 every cycle and wraps 0xFFFF_FFFF -> 0. A write loads `WriteData` and suppresses the increment that cycle.
- A write to TL loads `WriteData` and suppresses the increment and reload that cycle.
- A write to TCON loads bits [2:0] from `WriteData`. If an overflow reload with TCON[1] = 1 occurs in the same cycle, TCON[2] is set regardless of the written bit2 (set wins). Bits 0 and 1 take the written values.
- A write to TH takes effect on the next reload, including a reload occurring in the same cycle: the reload uses the old TH.
- `ReadData` returns the current register contents (pre-edge values) whenever `MemRead = 1` and the address hits. Otherwise it is 0.
- Scan: 16-bit prescaler counts 0..SCAN_DIV-1. On terminal count it returns to 0 and a 2-bit digit index advances 0->1->2->3->0.
- `an[i] = 0` only for i == index.
- `seg` = active-low hex decode of DIGITS nibble[index], covering 0-F. Standard patterns: 0 -> 7'b1000000, 8 -> 7'b0000000, F -> 7'b0001110.

## Timing
- Reset (async, immediate): TH = 0, TL = 0, TCON = 0, LED = 0, DIGITS = 0, SYSTICK = 0, prescaler = 0, index = 0.
- Outputs while in reset: `leds` = 0, `irq` = 0, `an` = 4'b1110, `seg` = 7'b1000000. `ReadData` is combinational and follows the register values.
- Write latency: the value is visible on `ReadData` in the cycle after the `MemWrite` edge, with 0 cycles of combinational delay for reads.
- Timer overflow: with TL = 0xFFFF_FFFF and TCON = 3'b011 at edge k, TL = TH and `irq` = 1 after edge k.
- `irq` stays high until software writes TCON with bit2 = 0, or until reset.
- Digit dwell is exactly SCAN_DIV cycles. With SCAN_DIV = 1, the index advances every cycle.
- Reset asserted mid-count clears all counters. Counting resumes from 0 on the first edge after deassertion.
- `MemRead` and `MemWrite` both asserted to the same register: the read returns the old value and the write commits at the edge.

## Test plan
- Reset, then read all six offsets -> ReadData = 0 each. Read 0x4000_0018 -> 0. `an` = 4'b1110, `seg` = 7'b1000000.
- Write TH = 0xFFFF_FFF0, TL = 0xFFFF_FFFD, TCON = 3 -> TL reads ...FE, then ...FF, then reloads to 0xFFFF_FFF0. `irq` rises the same cycle as the reload and TCON reads 7.
- With `irq` = 1, write TCON = 3 -> `irq` = 0 next cycle. Write TCON = 3 in the exact reload cycle -> TCON[2] = 1 (set wins).
- Write TL = 5 while enabled -> next read is 5, not 6. Write SYSTICK = 0xFFFF_FFFF -> it reads 0 one cycle later.
- SCAN_DIV = 2, DIGITS = 16'h8F10 -> `an` sequence 1110, 1101, 1011, 0111, each held 2 cycles. `seg` sequence 1000000, 1111001, 0001110, 0000000.
- Write LED = 0x1A5 -> `leds` = 8'hA5 and reads back 0xA5. Assert reset mid-run -> all outputs return to reset values immediately.
